// File: rtl/sprite_writer.sv
// sprite_writer: walks a sprite row-major, fetches each pixel from a
// synchronous sprite ROM and issues one program write per visible pixel
// towards the SRAM controller. Transparent-key pixels and pixels that land
// at or beyond SCREEN_W/SCREEN_H are skipped.
//
// Optional feature: define SPRITE_HFLIP_EN to add the hflip input, which
// mirrors the ROM column order while keeping screen placement unchanged.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 one-cycle draw request, honoured only when idle
//   sprite_x, sprite_y    screen position of sprite pixel (0,0)
//   sprite_w, sprite_h    sprite size in pixels (0 finishes immediately)
//   rom_base              ROM address of sprite pixel (0,0)
//   rom_addr / rom_data   sprite ROM port; data valid one cycle after address
//   program_x/_y/_data    write position and RGB565 colour
//   program_write         write request, held until program_ready
//   program_ready         controller accepts the write this cycle
//   hflip                 (SPRITE_HFLIP_EN only) mirror sprite horizontally
//   busy                  draw in progress
//   done                  one-cycle pulse when the sprite is finished
module sprite_writer #(
  parameter int unsigned SIZE_W      = 6,
  parameter int unsigned ROM_AW      = 16,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter logic [15:0] TRANSPARENT = 16'hF81F
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic [SIZE_W-1:0] sprite_w,
  input  logic [SIZE_W-1:0] sprite_h,
  input  logic [ROM_AW-1:0] rom_base,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [9:0]        program_x,
  output logic [9:0]        program_y,
  output logic [15:0]       program_data,
  output logic              program_write,
  input  logic              program_ready,
`ifdef SPRITE_HFLIP_EN
  input  logic              hflip,
`endif
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, DONE} state_t;
  state_t state, state_n;

  logic [9:0]        x_q, y_q;
  logic [SIZE_W-1:0] w_q, h_q, col, row;
  logic [ROM_AW-1:0] rowptr;

  logic [10:0]       sx, sy;
  logic              skip, last_col, last_row, fin, zero_size, advance;
  logic [SIZE_W-1:0] adv_col, adv_rom_col, start_rom_col;
  logic [ROM_AW-1:0] adv_rowptr, adv_addr;

`ifdef SPRITE_HFLIP_EN
  logic flip_q;
`endif

  // Pixel evaluation, 11-bit sums so a position past column/row 1023 cannot
  // wrap back onto the visible screen.
  always_comb begin
    sx        = {1'b0, x_q} + 11'(col);
    sy        = {1'b0, y_q} + 11'(row);
    skip      = (rom_data == TRANSPARENT) || (sx >= 11'(SCREEN_W)) ||
                (sy >= 11'(SCREEN_H));
    last_col  = (col == w_q - SIZE_W'(1));
    last_row  = (row == h_q - SIZE_W'(1));
    fin       = last_col && last_row;
    zero_size = (sprite_w == '0) || (sprite_h == '0);
    advance   = ((state == DATA) && skip) || ((state == WRITE) && program_ready);
  end

  // Address of the next pixel, formed while leaving the current one so that
  // rom_addr is already stable throughout ADDR and the ROM returns data in DATA.
  always_comb begin
    adv_col    = last_col ? '0 : col + SIZE_W'(1);
    adv_rowptr = last_col ? rowptr + ROM_AW'(w_q) : rowptr;
`ifdef SPRITE_HFLIP_EN
    adv_rom_col   = flip_q ? w_q - SIZE_W'(1) - adv_col : adv_col;
    start_rom_col = hflip ? sprite_w - SIZE_W'(1) : '0;
`else
    adv_rom_col   = adv_col;
    start_rom_col = '0;
`endif
    adv_addr = adv_rowptr + ROM_AW'(adv_rom_col);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = zero_size ? DONE : ADDR;
      ADDR:    state_n = DATA;
      DATA:    if (skip) state_n = fin ? DONE : ADDR;
               else      state_n = WRITE;
      WRITE:   if (program_ready) state_n = fin ? DONE : ADDR;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr      <= '0;
      program_x     <= '0;
      program_y     <= '0;
      program_data  <= '0;
      program_write <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      w_q           <= '0;
      h_q           <= '0;
      col           <= '0;
      row           <= '0;
      rowptr        <= '0;
`ifdef SPRITE_HFLIP_EN
      flip_q        <= 1'b0;
`endif
    end else begin
      // DONE is only ever entered for one cycle, so these track the state.
      done <= (state_n == DONE);
      busy <= (state_n == ADDR) || (state_n == DATA) || (state_n == WRITE);

      if ((state == IDLE) && start) begin
        x_q      <= sprite_x;
        y_q      <= sprite_y;
        w_q      <= sprite_w;
        h_q      <= sprite_h;
        col      <= '0;
        row      <= '0;
        rowptr   <= rom_base;
        rom_addr <= rom_base + ROM_AW'(start_rom_col);
`ifdef SPRITE_HFLIP_EN
        flip_q   <= hflip;
`endif
      end

      if ((state == DATA) && !skip) begin
        program_x     <= sx[9:0];
        program_y     <= sy[9:0];
        program_data  <= rom_data;
        program_write <= 1'b1;
      end

      if ((state == WRITE) && program_ready) program_write <= 1'b0;

      if (advance) begin
        col    <= adv_col;
        rowptr <= adv_rowptr;
        if (last_col) row <= row + SIZE_W'(1);
        if (!fin) rom_addr <= adv_addr;
      end
    end
  end

endmodule

// File: tb/tb_sprite_writer.sv
module tb_sprite_writer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  sprite_x = '0;
  logic [9:0]  sprite_y = '0;
  logic [5:0]  sprite_w = '0;
  logic [5:0]  sprite_h = '0;
  logic [15:0] rom_base = '0;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic [9:0]  program_x, program_y;
  logic [15:0] program_data;
  logic        program_write;
  logic        program_ready = 1'b1;
  logic        busy, done;
`ifdef SPRITE_HFLIP_EN
  logic        hflip = 1'b0;
`endif

  sprite_writer #(.SIZE_W(6), .ROM_AW(16), .SCREEN_W(640), .SCREEN_H(480),
                  .TRANSPARENT(16'hF81F)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_w(sprite_w), .sprite_h(sprite_h), .rom_base(rom_base),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .program_x(program_x), .program_y(program_y), .program_data(program_data),
    .program_write(program_write), .program_ready(program_ready),
`ifdef SPRITE_HFLIP_EN
    .hflip(hflip),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous sprite ROM
  logic [15:0] mem [64];
  always @(posedge clk) rom_data <= mem[rom_addr[5:0]];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  logic [9:0]  qx[$];
  logic [9:0]  qy[$];
  logic [15:0] qd[$];
  int          qc[$];

  always @(posedge clk) cyc++;

  // Record every accepted write
  always @(negedge clk) begin
    if (program_write && program_ready) begin
      qx.push_back(program_x);
      qy.push_back(program_y);
      qd.push_back(program_data);
      qc.push_back(cyc);
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic clear_log();
    qx.delete(); qy.delete(); qd.delete(); qc.delete();
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic load_rom(input logic [15:0] a, b, c, d);
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  task automatic do_start(input logic [9:0] x, y, input logic [5:0] w, h,
                          input logic [15:0] base, input logic f);
    @(posedge clk); #1;
    sprite_x = x; sprite_y = y; sprite_w = w; sprite_h = h; rom_base = base;
`ifdef SPRITE_HFLIP_EN
    hflip = f;
`else
    if (f) $display("note: hflip request ignored in this build");
`endif
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({rom_addr, program_x, program_y, program_data, program_write, busy, done} !== '0)
      begin bad++; $display("FAIL reset: addr=%h x=%0d y=%0d d=%h w=%b busy=%b done=%b required all 0",
        rom_addr, program_x, program_y, program_data, program_write, busy, done); end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    logic [9:0]  ex [4] = '{10'd100, 10'd101, 10'd100, 10'd101};
    logic [9:0]  ey [4] = '{10'd50, 10'd50, 10'd51, 10'd51};
    logic [15:0] ed [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
    load_rom(16'd1, 16'd2, 16'd3, 16'd4);
    clear_log();
    program_ready = 1'b1;
    do_start(10'd100, 10'd50, 6'd2, 6'd2, 16'd0, 1'b0);
    wait_done(40, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_done: no done pulse within 40 cycles"); end
    total++;
    if (qx.size() !== 4) begin bad++; $display("FAIL basic_count: got %0d writes, required 4", qx.size()); end
    for (int i = 0; i < 4 && i < qx.size(); i++) begin
      total++;
      if (qx[i] !== ex[i] || qy[i] !== ey[i] || qd[i] !== ed[i]) begin
        bad++;
        $display("FAIL basic_write%0d: got (%0d,%0d,%h) required (%0d,%0d,%h)",
                 i, qx[i], qy[i], qd[i], ex[i], ey[i], ed[i]);
      end
    end
    total++;
    if (qc.size() > 0 && qc[0] - start_cyc !== 3) begin
      bad++; $display("FAIL basic_latency: got %0d cycles, required 3", qc[0] - start_cyc);
    end
    total++;
    if (busy_cnt !== 12) begin bad++; $display("FAIL basic_busy_cycles: got %0d, required 12", busy_cnt); end
    total++;
    if (done_cnt !== 1 || done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_done_pulse: pulses=%0d done=%b busy=%b required 1,0,0", done_cnt, done, busy);
    end
  endtask

  task automatic test_transparent();
    bit ok;
    logic [9:0]  ex [3] = '{10'd100, 10'd100, 10'd101};
    logic [9:0]  ey [3] = '{10'd50, 10'd51, 10'd51};
    logic [15:0] ed [3] = '{16'd1, 16'd3, 16'd4};
    load_rom(16'd1, 16'hF81F, 16'd3, 16'd4);
    clear_log();
    do_start(10'd100, 10'd50, 6'd2, 6'd2, 16'd0, 1'b0);
    wait_done(40, ok);
    total++;
    if (!ok || qx.size() !== 3) begin
      bad++; $display("FAIL transparent_count: done=%b writes=%0d required 1,3", ok, qx.size());
    end
    for (int i = 0; i < 3 && i < qx.size(); i++) begin
      total++;
      if (qx[i] !== ex[i] || qy[i] !== ey[i] || qd[i] !== ed[i]) begin
        bad++;
        $display("FAIL transparent_write%0d: got (%0d,%0d,%h) required (%0d,%0d,%h)",
                 i, qx[i], qy[i], qd[i], ex[i], ey[i], ed[i]);
      end
    end
  endtask

  task automatic test_clipping();
    bit ok;
    load_rom(16'd1, 16'd2, 16'd3, 16'd4);
    clear_log();
    do_start(10'd639, 10'd479, 6'd2, 6'd2, 16'd0, 1'b0);
    wait_done(40, ok);
    total++;
    if (!ok || qx.size() !== 1) begin
      bad++; $display("FAIL clip_count: done=%b writes=%0d required 1,1", ok, qx.size());
    end
    total++;
    if (qx.size() > 0 && (qx[0] !== 10'd639 || qy[0] !== 10'd479 || qd[0] !== 16'd1)) begin
      bad++; $display("FAIL clip_write: got (%0d,%0d,%h) required (639,479,0001)", qx[0], qy[0], qd[0]);
    end
  endtask

  task automatic test_zero_size();
    bit ok;
    clear_log();
    do_start(10'd10, 10'd10, 6'd0, 6'd3, 16'd0, 1'b0);
    wait_done(5, ok);
    total++;
    if (!ok || qx.size() !== 0 || busy_cnt !== 0) begin
      bad++; $display("FAIL zero_size: done=%b writes=%0d busy_cycles=%0d required 1,0,0", ok, qx.size(), busy_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen;
    logic [9:0]  ex [4] = '{10'd100, 10'd101, 10'd100, 10'd101};
    logic [15:0] ed [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
    load_rom(16'd1, 16'd2, 16'd3, 16'd4);
    clear_log();
    program_ready = 1'b0;
    do_start(10'd100, 10'd50, 6'd2, 6'd2, 16'd0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (program_write) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL bp_first_write: no program_write within 10 cycles"); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (program_write !== 1'b1 || program_x !== 10'd100 || program_y !== 10'd50 ||
          program_data !== 16'd1 || rom_addr !== 16'd0) begin
        bad++;
        $display("FAIL bp_hold%0d: got w=%b (%0d,%0d,%h) addr=%h required 1 (100,50,0001) addr=0000",
                 i, program_write, program_x, program_y, program_data, rom_addr);
      end
    end
    @(posedge clk); #1;
    program_ready = 1'b1;
    wait_done(40, ok);
    total++;
    if (!ok || qx.size() !== 4) begin
      bad++; $display("FAIL bp_count: done=%b writes=%0d required 1,4", ok, qx.size());
    end
    for (int i = 0; i < 4 && i < qx.size(); i++) begin
      total++;
      if (qx[i] !== ex[i] || qd[i] !== ed[i]) begin
        bad++; $display("FAIL bp_write%0d: got (%0d,%h) required (%0d,%h)", i, qx[i], qd[i], ex[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    load_rom(16'd1, 16'd2, 16'd3, 16'd4);
    do_start(10'd100, 10'd50, 6'd2, 6'd2, 16'd0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (program_write && program_y == 10'd51) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL rst_mid_reach: second-row write not seen"); end
    reset_n = 1'b0;
    #1;
    total++;
    if ({rom_addr, program_x, program_y, program_data, program_write, busy, done} !== '0)
      begin bad++; $display("FAIL rst_mid_async: addr=%h x=%0d y=%0d d=%h w=%b busy=%b required all 0",
        rom_addr, program_x, program_y, program_data, program_write, busy); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || program_write !== 1'b0) begin
      bad++; $display("FAIL rst_mid_idle: busy=%b write=%b required 0,0", busy, program_write);
    end
    clear_log();
    do_start(10'd100, 10'd50, 6'd2, 6'd2, 16'd0, 1'b0);
    wait_done(40, ok);
    total++;
    if (!ok || qx.size() !== 4 || qx[0] !== 10'd100 || qy[0] !== 10'd50 || qd[0] !== 16'd1 ||
        qx[3] !== 10'd101 || qy[3] !== 10'd51 || qd[3] !== 16'd4) begin
      bad++; $display("FAIL rst_mid_redraw: done=%b writes=%0d required 4 starting (100,50,1) ending (101,51,4)",
                      ok, qx.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    load_rom(16'd1, 16'd2, 16'd3, 16'd4);
    clear_log();
    do_start(10'd100, 10'd50, 6'd2, 6'd2, 16'd0, 1'b0);
    // A request while busy must be dropped
    repeat (3) @(posedge clk);
    #1;
    sprite_x = 10'd0; sprite_y = 10'd0; sprite_w = 6'd1; sprite_h = 6'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, ok);
    total++;
    if (!ok || qx.size() !== 4 || qx[0] !== 10'd100) begin
      bad++; $display("FAIL b2b_ignore: done=%b writes=%0d required 1,4", ok, qx.size());
    end
    // Wait_done returned one cycle after DONE, so this start lands in IDLE
    do_start(10'd200, 10'd10, 6'd1, 6'd1, 16'd3, 1'b0);
    wait_done(20, ok);
    total++;
    if (!ok || qx.size() !== 5 || done_cnt !== 2) begin
      bad++; $display("FAIL b2b_count: done=%b writes=%0d pulses=%0d required 1,5,2", ok, qx.size(), done_cnt);
    end
    total++;
    if (qx.size() == 5 && (qx[4] !== 10'd200 || qy[4] !== 10'd10 || qd[4] !== 16'd4)) begin
      bad++; $display("FAIL b2b_write: got (%0d,%0d,%h) required (200,10,0004)", qx[4], qy[4], qd[4]);
    end
  endtask

`ifdef SPRITE_HFLIP_EN
  task automatic test_hflip();
    bit ok;
    logic [9:0]  ex [4] = '{10'd100, 10'd101, 10'd100, 10'd101};
    logic [9:0]  ey [4] = '{10'd50, 10'd50, 10'd51, 10'd51};
    logic [15:0] ed [4] = '{16'd2, 16'd1, 16'd4, 16'd3};
    load_rom(16'd1, 16'd2, 16'd3, 16'd4);
    clear_log();
    do_start(10'd100, 10'd50, 6'd2, 6'd2, 16'd0, 1'b1);
    wait_done(40, ok);
    total++;
    if (!ok || qx.size() !== 4) begin
      bad++; $display("FAIL hflip_count: done=%b writes=%0d required 1,4", ok, qx.size());
    end
    for (int i = 0; i < 4 && i < qx.size(); i++) begin
      total++;
      if (qx[i] !== ex[i] || qy[i] !== ey[i] || qd[i] !== ed[i]) begin
        bad++;
        $display("FAIL hflip_write%0d: got (%0d,%0d,%h) required (%0d,%0d,%h)",
                 i, qx[i], qy[i], qd[i], ex[i], ey[i], ed[i]);
      end
    end
    hflip = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    test_reset();
    test_basic();
    test_transparent();
    test_clipping();
    test_zero_size();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef SPRITE_HFLIP_EN
    test_hflip();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
